sdcard_slot_mux: RTL
====================

Name: sdcard_slot_mux

Overview:
- Parametrised successor to the fixed two-card SD SPI steering in the board top levels.
- Routes one SD SPI master (the service processor) to one of NUM_SLOTS card sockets.
- Debounces and synchronises the per-slot card-detect pins and latches insert/remove events.
- Defers slot switches until the SPI bus is idle, so a transaction is never cut mid-frame.

Parameters:
- NUM_SLOTS, 2, number of card sockets (1..8).
- SEL_W, 3, width of slot index; must satisfy 2**SEL_W >= NUM_SLOTS.
- DEBOUNCE_CYCLES, 65536, consecutive stable clk cycles required to accept a card-detect change.
- IDLE_CYCLES, 8, consecutive clk cycles host_cs must be low before a pending switch is taken.
- CD_ACTIVE_LOW, 1, 1 = socket CD pin reads 0 when a card is present.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_sel  in  SEL_W  requested slot index
- req_valid  in  1  one-cycle strobe: load req_sel as pending request
- cur_sel  out  SEL_W  slot currently routed
- sel_busy  out  1  switch pending or in progress
- host_cs  in  1  host chip select, active-high
- host_sck  in  1  host SPI clock
- host_mosi  in  1  host MOSI
- host_miso  out  1  MISO from current slot
- host_cd  out  1  debounced card present, current slot
- host_wp  out  1  write protect, current slot
- cd_state  out  NUM_SLOTS  debounced presence, all slots
- cd_changed  out  NUM_SLOTS  sticky change flags
- cd_clear  in  NUM_SLOTS  write-1-to-clear for cd_changed
- pad_cs_n  out  NUM_SLOTS  per-slot DAT3/CS, active-low
- pad_sck  out  NUM_SLOTS  per-slot SCK
- pad_mosi  out  NUM_SLOTS  per-slot CMD
- pad_miso  in  NUM_SLOTS  per-slot DAT0
- pad_cd  in  NUM_SLOTS  raw card-detect
- pad_wp  in  NUM_SLOTS  raw write-protect; tie 0 if absent

Behaviour:
- Reset values:
  - cur_sel=0, sel_busy=0, state=RUN.
  - cd_state=0, cd_changed=0, debounce counters=0.
  - All pads idle: pad_cs_n=1, pad_sck=0, pad_mosi=0.
- Pad routing:
  - Selected slot in RUN: pad_cs_n=~host_cs, pad_sck=host_sck, pad_mosi=host_mosi.
  - All other slots, and every slot in SWITCH: idle values.
  - Pad outputs are combinational from host inputs and state; no added latency on SCK/MOSI.
- host_miso = pad_miso[cur_sel], combinational; 1 in SWITCH.
- host_cd = cd_state[cur_sel]; host_wp = synchronised pad_wp[cur_sel] & host_cd.
- Synchronisers: pad_cd and pad_wp each pass through 2 flops. Polarity is normalised to 1 = present per CD_ACTIVE_LOW.
- Debounce, per slot:
  - The counter resets whenever the synced value equals cd_state.
  - Otherwise the counter increments. On reaching DEBOUNCE_CYCLES-1, cd_state toggles, the counter clears, and cd_changed is set.
  - Boundary: a glitch shorter than DEBOUNCE_CYCLES never changes cd_state.
- cd_changed: a set in the same cycle as a cd_clear bit for the same slot wins; the flag ends at 1.
- Slot-switch FSM states: RUN, DRAIN, SWITCH.
  - RUN: req_valid with req_sel < NUM_SLOTS and req_sel != cur_sel latches pending, sets sel_busy=1, goes to DRAIN. A request equal to cur_sel or out of range is ignored.
  - DRAIN: an idle counter counts cycles with host_cs=0 and resets to 0 on host_cs=1. At IDLE_CYCLES consecutive idle cycles, go to SWITCH. A new req_valid overwrites pending; if it equals cur_sel, return to RUN with sel_busy=0.
  - SWITCH: exactly 1 cycle with all pads idle; cur_sel<=pending; then RUN with sel_busy=0 (cleared when cur_sel updates).
  - req_valid in SWITCH is ignored.
- Card removal on the selected slot does not force a switch. host_cd drops, and the host is responsible for aborting.
- Reset asserted mid-operation returns all state to reset values in the next cycle.

Decomposition:
- Shared package sd_mux_pkg: FSM state enum (RUN, DRAIN, SWITCH), pad idle-level constants.
- One sub-module: sdcard_cd_debounce (2-flop sync, counter, change pulse), instantiated NUM_SLOTS times in a generate loop.
- Routing and FSM stay in the top module.

Test Plan (NUM_SLOTS=3, DEBOUNCE_CYCLES=16, IDLE_CYCLES=4, CD_ACTIVE_LOW=1):
- Reset → pad_cs_n=3'b111, pad_sck=0, cur_sel=0, cd_state=0, cd_changed=0, sel_busy=0.
- Drive pad_cd[1]=0 steady → cd_state[1]=1 and cd_changed[1]=1 exactly 2+16 cycles later. A 10-cycle low pulse on pad_cd[2] leaves cd_state[2]=0.
- Hold host_cs=1, pulse req_valid with req_sel=2 → sel_busy=1 and cur_sel stays 0 while CS is high. Drop CS; after 4 idle cycles plus 1 SWITCH cycle → cur_sel=2, sel_busy=0, pads idle during SWITCH.
- In DRAIN, pulse host_cs high on idle cycle 3 → idle count restarts and the switch occurs 4 idle cycles after CS falls again.
- req_sel=5 or req_sel=cur_sel → ignored, sel_busy stays 0. In DRAIN, req_sel=cur_sel → back to RUN, no switch.
- cd_clear[1]=1 in the same cycle as a new debounced removal on slot 1 → cd_changed[1] remains 1. Next clear → 0.

Source files
------------

// File: rtl/sd_mux_pkg.sv
// Shared types and constants for the SD card slot multiplexer.
package sd_mux_pkg;

  // Slot-switch sequencing states.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2
  } mux_state_e;

  // Levels driven on a socket that is not connected to the host.
  localparam logic PAD_CS_N_IDLE = 1'b1;
  localparam logic PAD_SCK_IDLE  = 1'b0;
  localparam logic PAD_MOSI_IDLE = 1'b0;

  // MISO level returned to the host while no socket is routed.
  localparam logic HOST_MISO_IDLE = 1'b1;

endpackage

// File: rtl/sdcard_cd_debounce.sv
// Per-socket card-detect / write-protect synchroniser and debouncer.
module sdcard_cd_debounce #(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter bit CD_ACTIVE_LOW   = 1'b1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic pad_cd_i,
  input  logic pad_wp_i,
  output logic cd_state_o,
  output logic wp_sync_o,
  output logic change_o
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Raw pin level meaning "no card", so reset never looks like an insertion.
  localparam logic CD_ABSENT_RAW = CD_ACTIVE_LOW;

  logic [1:0]       cd_sync_q, wp_sync_q;
  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             present;

  assign present = CD_ACTIVE_LOW ? ~cd_sync_q[1] : cd_sync_q[1];

  // Count consecutive cycles the synced level disagrees with the accepted state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    change_o = 1'b0;
    if (present != state_q) begin
      if (cnt_q == CNT_LAST) begin
        state_d  = ~state_q;
        change_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Two-flop synchronisers plus debounce state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cd_sync_q <= {2{CD_ABSENT_RAW}};
      wp_sync_q <= 2'b00;
      state_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      cd_sync_q <= {cd_sync_q[0], pad_cd_i};
      wp_sync_q <= {wp_sync_q[0], pad_wp_i};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
    end
  end

  assign cd_state_o = state_q;
  assign wp_sync_o  = wp_sync_q[1];

endmodule

// File: rtl/sdcard_slot_mux.sv
// Steers one SPI host onto one of NUM_SLOTS SD sockets; switches only when the bus is idle.
module sdcard_slot_mux
  import sd_mux_pkg::*;
#(
  parameter int NUM_SLOTS       = 2,
  parameter int SEL_W           = 3,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int IDLE_CYCLES     = 8,
  parameter bit CD_ACTIVE_LOW   = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [SEL_W-1:0]     req_sel_i,
  input  logic                 req_valid_i,
  output logic [SEL_W-1:0]     cur_sel_o,
  output logic                 sel_busy_o,
  input  logic                 host_cs_i,
  input  logic                 host_sck_i,
  input  logic                 host_mosi_i,
  output logic                 host_miso_o,
  output logic                 host_cd_o,
  output logic                 host_wp_o,
  output logic [NUM_SLOTS-1:0] cd_state_o,
  output logic [NUM_SLOTS-1:0] cd_changed_o,
  input  logic [NUM_SLOTS-1:0] cd_clear_i,
  output logic [NUM_SLOTS-1:0] pad_cs_n_o,
  output logic [NUM_SLOTS-1:0] pad_sck_o,
  output logic [NUM_SLOTS-1:0] pad_mosi_o,
  input  logic [NUM_SLOTS-1:0] pad_miso_i,
  input  logic [NUM_SLOTS-1:0] pad_cd_i,
  input  logic [NUM_SLOTS-1:0] pad_wp_i
);
  localparam int IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam logic [IW-1:0]  IDLE_LAST = IW'(IDLE_CYCLES - 1);
  localparam logic [SEL_W:0] SLOTS_W   = (SEL_W+1)'(NUM_SLOTS);

  mux_state_e          state_q;
  logic [SEL_W-1:0]    cur_sel_q, pend_q;
  logic                busy_q;
  logic [IW-1:0]       idle_q;
  logic [NUM_SLOTS-1:0] cd_changed_q, cd_changed_d, chg, wp_sync;
  logic                req_ok, sel_miso, sel_cd, sel_wp;

  assign req_ok = {1'b0, req_sel_i} < SLOTS_W;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    localparam logic [SEL_W-1:0] IDX = SEL_W'(g);
    logic route;

    sdcard_cd_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CD_ACTIVE_LOW  (CD_ACTIVE_LOW)
    ) u_deb (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .pad_cd_i  (pad_cd_i[g]),
      .pad_wp_i  (pad_wp_i[g]),
      .cd_state_o(cd_state_o[g]),
      .wp_sync_o (wp_sync[g]),
      .change_o  (chg[g])
    );

    // The routed socket stays connected through DRAIN so the frame in flight completes.
    assign route         = (state_q != ST_SWITCH) && (cur_sel_q == IDX);
    assign pad_cs_n_o[g] = route ? ~host_cs_i  : PAD_CS_N_IDLE;
    assign pad_sck_o[g]  = route ? host_sck_i  : PAD_SCK_IDLE;
    assign pad_mosi_o[g] = route ? host_mosi_i : PAD_MOSI_IDLE;
  end

  // Select the current socket's return signals.
  always_comb begin
    sel_miso = 1'b0;
    sel_cd   = 1'b0;
    sel_wp   = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (cur_sel_q == SEL_W'(i)) begin
        sel_miso = pad_miso_i[i];
        sel_cd   = cd_state_o[i];
        sel_wp   = wp_sync[i];
      end
    end
  end

  assign host_miso_o = (state_q == ST_SWITCH) ? HOST_MISO_IDLE : sel_miso;
  assign host_cd_o   = sel_cd;
  assign host_wp_o   = sel_wp & sel_cd;

  // Sticky change flags; a new event beats a simultaneous clear.
  assign cd_changed_d = (cd_changed_q & ~cd_clear_i) | chg;

  always_ff @(posedge clk_i) begin
    if (reset_i) cd_changed_q <= '0;
    else         cd_changed_q <= cd_changed_d;
  end

  assign cd_changed_o = cd_changed_q;

  // Slot-switch sequencer: RUN -> DRAIN (wait for idle bus) -> SWITCH (one dead cycle).
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_RUN;
      cur_sel_q <= '0;
      pend_q    <= '0;
      busy_q    <= 1'b0;
      idle_q    <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (req_valid_i && req_ok && (req_sel_i != cur_sel_q)) begin
            pend_q  <= req_sel_i;
            busy_q  <= 1'b1;
            idle_q  <= '0;
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (req_valid_i && (req_sel_i == cur_sel_q)) begin
            busy_q  <= 1'b0;
            state_q <= ST_RUN;
          end else begin
            if (req_valid_i && req_ok) pend_q <= req_sel_i;
            if (host_cs_i)                idle_q  <= '0;
            else if (idle_q == IDLE_LAST) state_q <= ST_SWITCH;
            else                          idle_q  <= idle_q + 1'b1;
          end
        end
        ST_SWITCH: begin
          cur_sel_q <= pend_q;
          busy_q    <= 1'b0;
          state_q   <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign cur_sel_o  = cur_sel_q;
  assign sel_busy_o = busy_q;

endmodule
